universal_shift_engine: RTL

UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

---
 rtl/universal_shift_engine.sv | 138 +++++++++++++
 1 files changed

// File: rtl/universal_shift_engine.sv
// Universal shift register with a three-state sequencer that performs
// LOAD, CLR, NOP and multi-cycle 1-bit-per-clock shifts and rotates.
module universal_shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] out_o,
    output logic             serial_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    state_e           r_state;
    op_e              r_op;
    logic [AMT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_serial;
    logic             r_busy;
    logic             r_done;

    op_e              w_op_in;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_step_out;
    logic             w_step_bit;

    assign w_op_in    = op_e'(op_i);
    assign w_is_shift = (op_i >= OP_SHL) && (op_i <= OP_ASR);

    // One 1-bit step of the latched operation; used only in S_SHIFT.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_step_out = r_out;
        w_step_bit = r_serial;
        unique case (r_op)
            OP_SHL: begin
                w_step_out = {r_out[WIDTH-2:0], serial_i};
                w_step_bit = r_out[WIDTH-1];
            end
            OP_SHR: begin
                w_step_out = {serial_i, r_out[WIDTH-1:1]};
                w_step_bit = r_out[0];
            end
            OP_ROL: begin
                w_step_out = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                w_step_bit = r_out[WIDTH-1];
            end
            OP_ROR: begin
                w_step_out = {r_out[0], r_out[WIDTH-1:1]};
                w_step_bit = r_out[0];
            end
            OP_ASR: begin
                w_step_out = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
                w_step_bit = r_out[0];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NOP;
            r_count  <= '0;
            r_out    <= '0;
            r_serial <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_op    <= w_op_in;
                        r_count <= amount_i;
                        if (w_is_shift && (amount_i != '0)) begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            if (w_op_in == OP_LOAD) r_out <= word_i;
                            else if (w_op_in == OP_CLR) r_out <= '0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_out    <= w_step_out;
                    r_serial <= w_step_bit;
                    r_count  <= r_count - 1'b1;
                    if (r_count == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o    = r_out;
    assign serial_o = r_serial;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule
